// File: rtl/data_memory_controller.sv
`default_nettype none
// ============================================================================
// data_memory_controller : req/ack handshake between the core's load/store
// datapath and a variable-latency single-port data bus.
// Optional feature macro: DMC_TIMEOUT_EN (REQ timeout abort with bus_error).
// Revision: 1.0
// ============================================================================
module data_memory_controller #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_mask,
  output logic [31:0]           read_data,
  output logic                  read_done,
  output logic                  write_done,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_wmask_q, mem_wmask_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    read_done_q, read_done_d;
  logic                    write_done_q, write_done_d;

`ifdef DMC_TIMEOUT_EN
  localparam int              CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_error_q, bus_error_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    read_data_d  = read_data_q;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
`ifdef DMC_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    bus_error_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef DMC_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        // Stores win when both enables are high.
        if (write_enable) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = address;
          mem_wdata_d = write_data;
          mem_wmask_d = write_mask;
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end else if (read_enable) begin
          mem_we_d    = 1'b0;
          mem_addr_d  = address;
          mem_wmask_d = 4'b0000;
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            read_data_d = mem_rdata;
          end
          read_done_d  = ~mem_we_q;
          write_done_d = mem_we_q;
          mem_req_d    = 1'b0;
          state_d      = RESP;
        end
`ifdef DMC_TIMEOUT_EN
        // An ack arriving on the limit cycle takes the branch above instead.
        else if (tmo_cnt_q == TIMEOUT_LIMIT) begin
          read_done_d  = ~mem_we_q;
          write_done_d = mem_we_q;
          bus_error_d  = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      // Done pulse is visible here; the finishing instruction's enable is ignored.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      read_data_q  <= read_data_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
    end
  end

`ifdef DMC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign read_data  = read_data_q;
  assign read_done  = read_done_q;
  assign write_done = write_done_q;

endmodule
`default_nettype wire
